branch_resolve_unit: RTL and testbench

//  Write side of the BTB: consumes resolved branches from EX, compares outcome against the IF-stage prediction.

---
 rtl/bpu_pkg.sv | 29 ++
 rtl/bru_update_fifo.sv | 52 +++++
 rtl/branch_resolve_unit.sv | 108 ++++++++++
 tb/tb_branch_resolve_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared types and helpers for the BTB write side (branch_resolve_unit).
// Address width comes from `ADDR_WIDTH, defaulting to 32 when not supplied.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package bpu_pkg;
  localparam int AW           = `ADDR_WIDTH;
  localparam int UQ_DEPTH_DEF = 4;

  // One BTB update: set=1 installs pc->target, set=0 invalidates pc's entry
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [AW-1:0] target;
    logic          set;
  } bpu_upd_t;

  // Outcome disagrees with fetch prediction, including a BTB hit on a non-branch
  function automatic logic bru_mispredict(input logic          is_branch,
                                          input logic          pred_taken,
                                          input logic [AW-1:0] pred_target,
                                          input logic          act_taken,
                                          input logic [AW-1:0] act_target);
    logic dir_miss, tgt_miss;
    dir_miss = (pred_taken != act_taken);
    tgt_miss = act_taken & (pred_target != act_target);
    return is_branch ? (dir_miss | tgt_miss) : pred_taken;
  endfunction
endpackage

// File: rtl/bru_update_fifo.sv
// Synchronous FIFO of BTB update entries. Extra pointer MSB tells full from empty.
// A write while full is dropped; no read-through when empty.
module bru_update_fifo
  import bpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW_P  = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_en,
  input  bpu_upd_t wr_data,
  output logic     full,
  output logic     empty,
  output logic     rd_valid,
  input  logic     rd_ready,
  output bpu_upd_t rd_data
);
  logic [AW_P:0] wptr_q, wptr_d, rptr_q, rptr_d;
  bpu_upd_t      mem_q [DEPTH];
  logic          do_wr, do_rd;

  assign full     = (wptr_q[AW_P] != rptr_q[AW_P]) &&
                    (wptr_q[AW_P-1:0] == rptr_q[AW_P-1:0]);
  assign empty    = (wptr_q == rptr_q);
  assign do_wr    = wr_en & ~full;
  assign do_rd    = rd_ready & ~empty;
  assign rd_valid = ~empty;
  assign rd_data  = mem_q[rptr_q[AW_P-1:0]];

  // Pointer advance; both may move in the same cycle
  always_comb begin
    wptr_d = wptr_q + (AW_P+1)'(do_wr);
    rptr_d = rptr_q + (AW_P+1)'(do_rd);
  end

  // Pointers reset to empty; contents are simply abandoned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage, written at the tail slot
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW_P-1:0]] <= wr_data;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX branches against the fetch prediction: registered redirect on
// mispredict, queued BTB set/invalidate writes drained one per cycle.
// Optional perf counters enabled by defining BRU_PERF_CNT_EN.
module branch_resolve_unit
  import bpu_pkg::*;
#(
  parameter int UQ_DEPTH = 4,
  parameter int UQ_AW    = 2,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  logic [`ADDR_WIDTH-1:0] ex_pc,
  input  logic                   ex_is_branch,
  input  logic                   ex_pred_taken,
  input  logic [`ADDR_WIDTH-1:0] ex_pred_target,
  input  logic                   ex_act_taken,
  input  logic [`ADDR_WIDTH-1:0] ex_act_target,
  output logic                   redirect_valid,
  output logic [`ADDR_WIDTH-1:0] redirect_pc,
  output logic                   upd_valid,
  input  logic                   upd_ready,
  output logic [`ADDR_WIDTH-1:0] upd_pc,
  output logic [`ADDR_WIDTH-1:0] upd_target,
  output logic                   upd_set,
  output logic [CNT_W-1:0]       perf_br_cnt,
  output logic [CNT_W-1:0]       perf_mp_cnt
);
  logic                   accept, mispred, enq, uq_full, uq_empty;
  logic                   redir_v_q, redir_v_d;
  logic [`ADDR_WIDTH-1:0] redir_pc_q, redir_pc_d;
  bpu_upd_t               enq_ent, head;

  assign ex_ready = ~uq_full;
  assign accept   = ex_valid & ex_ready;
  assign mispred  = bru_mispredict(ex_is_branch, ex_pred_taken, ex_pred_target,
                                   ex_act_taken, ex_act_target);
  assign enq      = accept & mispred;

  // Build the update entry; a not-taken or non-branch outcome invalidates
  always_comb begin
    enq_ent        = '0;
    enq_ent.pc     = ex_pc;
    enq_ent.target = ex_act_target;
    enq_ent.set    = ex_is_branch & ex_act_taken;
  end

  bru_update_fifo #(.DEPTH(UQ_DEPTH), .AW_P(UQ_AW)) u_uq (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (enq),
    .wr_data  (enq_ent),
    .full     (uq_full),
    .empty    (uq_empty),
    .rd_valid (upd_valid),
    .rd_ready (upd_ready),
    .rd_data  (head)
  );

  assign upd_pc     = head.pc;
  assign upd_target = head.target;
  assign upd_set    = head.set;

  // Next redirect: pulse only after a mispredicting accept, pc held otherwise
  always_comb begin
    redir_v_d  = enq;
    redir_pc_d = redir_pc_q;
    if (enq)
      redir_pc_d = (ex_is_branch & ex_act_taken) ? ex_act_target : ex_pc + `ADDR_WIDTH'(4);
  end

  // Redirect register; reset cancels a pending pulse immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_v_q  <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      redir_v_q  <= redir_v_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign redirect_valid = redir_v_q;
  assign redirect_pc    = redir_pc_q;

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] br_cnt_q, mp_cnt_q;

  // Free-running event counters, wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_q + CNT_W'(accept & ex_is_branch);
      mp_cnt_q <= mp_cnt_q + CNT_W'(enq);
    end
  end

  assign perf_br_cnt = br_cnt_q;
  assign perf_mp_cnt = mp_cnt_q;
`else
  assign perf_br_cnt = '0;
  assign perf_mp_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a queue-based reference model.
module tb_branch_resolve_unit;
  localparam int A = `ADDR_WIDTH;

  logic         clk = 0, rst = 1;
  logic         ex_valid = 0, ex_is_branch = 0, ex_pred_taken = 0, ex_act_taken = 0;
  logic [A-1:0] ex_pc = 0, ex_pred_target = 0, ex_act_target = 0;
  logic         upd_ready = 0;
  logic         ex_ready, redirect_valid, upd_valid, upd_set;
  logic [A-1:0] redirect_pc, upd_pc, upd_target;
  logic [31:0]  perf_br_cnt, perf_mp_cnt;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_is_branch(ex_is_branch), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_act_taken(ex_act_taken), .ex_act_target(ex_act_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_set(upd_set), .perf_br_cnt(perf_br_cnt), .perf_mp_cnt(perf_mp_cnt)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending updates plus a redirect flag
  typedef struct { logic [A-1:0] pc; logic [A-1:0] tgt; bit set; } ent_t;
  ent_t         mq[$];
  bit           m_rv, m_acc, m_mp, m_deq;
  logic [A-1:0] m_rpc = 0;
  int unsigned  m_br = 0, m_mpc = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete(); m_rv = 0; m_rpc = 0; m_br = 0; m_mpc = 0;
    end else begin
      m_acc = ex_valid && (mq.size() < 4);
      m_deq = (mq.size() > 0) && upd_ready;
      if (ex_is_branch)
        m_mp = (ex_pred_taken != ex_act_taken) || (ex_act_taken && ex_pred_target != ex_act_target);
      else
        m_mp = ex_pred_taken;
      if (m_deq) void'(mq.pop_front());
      m_rv = m_acc && m_mp;
      if (m_rv) begin
        m_rpc = (ex_is_branch && ex_act_taken) ? ex_act_target : ex_pc + 4;
        mq.push_back('{ex_pc, ex_act_target, ex_is_branch && ex_act_taken});
        m_mpc++;
      end
      if (m_acc && ex_is_branch) m_br++;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("ex_ready", ex_ready, mq.size() < 4);
      chk("upd_valid", upd_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("upd_pc", upd_pc, mq[0].pc);
        chk("upd_target", upd_target, mq[0].tgt);
        chk("upd_set", upd_set, mq[0].set);
      end
      chk("redirect_valid", redirect_valid, m_rv);
      if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
`ifdef BRU_PERF_CNT_EN
      chk("perf_br", perf_br_cnt, m_br);
      chk("perf_mp", perf_mp_cnt, m_mpc);
`else
      chk("perf_br", perf_br_cnt, 0);
      chk("perf_mp", perf_mp_cnt, 0);
`endif
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic set_in(input bit br, input logic [A-1:0] pc, input bit pt,
                        input logic [A-1:0] ptg, input bit at, input logic [A-1:0] atg);
    ex_valid = 1; ex_is_branch = br; ex_pc = pc; ex_pred_taken = pt;
    ex_pred_target = ptg; ex_act_taken = at; ex_act_target = atg;
  endtask

  task automatic send(input bit br, input logic [A-1:0] pc, input bit pt,
                      input logic [A-1:0] ptg, input bit at, input logic [A-1:0] atg);
    set_in(br, pc, pt, ptg, at, atg);
    tick();
    ex_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [A-1:0] exp_pc[4];
    #2;
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_perf_br", perf_br_cnt, 0);
    #5 rst = 0; chk_on = 1;
    tick();

    // 1: correct prediction
    upd_ready = 1;
    send(1, 'h1000, 1, 'h2000, 1, 'h2000);
    chk("t1_redirect", redirect_valid, 0);
    chk("t1_upd_valid", upd_valid, 0);

    // 2: direction miss
    upd_ready = 0;
    send(1, 'h1000, 0, 'h0, 1, 'h1800);
    chk("t2_redirect", redirect_valid, 1);
    chk("t2_redirect_pc", redirect_pc, 'h1800);
    chk("t2_upd_pc", upd_pc, 'h1000);
    chk("t2_upd_target", upd_target, 'h1800);
    chk("t2_upd_set", upd_set, 1);
    tick();
    chk("t2_pulse_one", redirect_valid, 0);
    upd_ready = 1; tick();
    chk("t2_drained", upd_valid, 0);

    // 3: false hit on a non-branch
    upd_ready = 0;
    send(0, 'h3004, 1, 'h5000, 0, 'h0);
    chk("t3_redirect_pc", redirect_pc, 'h3008);
    chk("t3_upd_pc", upd_pc, 'h3004);
    chk("t3_upd_set", upd_set, 0);
    upd_ready = 1; tick();

    // 4: backpressure, full, ordered drain, pointer wrap
    upd_ready = 0;
    for (int i = 1; i <= 4; i++) send(1, A'(i * 'h100), 0, 'h0, 1, A'(i * 'h100 + 'h40));
    chk("t4_full", ex_ready, 0);
    set_in(1, 'h500, 0, 'h0, 1, 'h540);
    tick();
    chk("t4_held", ex_ready, 0);
    chk("t4_head", upd_pc, 'h100);
    upd_ready = 1; tick();
    chk("t4_ready_back", ex_ready, 1);
    chk("t4_head2", upd_pc, 'h200);
    upd_ready = 0; tick();
    ex_valid = 0;
    chk("t4_refull", ex_ready, 0);
    exp_pc = '{A'('h200), A'('h300), A'('h400), A'('h500)};
    upd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_order", upd_pc, exp_pc[i]);
      tick();
    end
    chk("t4_empty", upd_valid, 0);
    send(1, 'h600, 0, 'h0, 1, 'h640);
    chk("t4_wrap_pc", upd_pc, 'h600);
    tick();
    chk("t4_wrap_empty", upd_valid, 0);

    // 5: asynchronous reset mid-operation
    upd_ready = 0;
    send(1, 'h700, 0, 'h0, 1, 'h740);
    send(1, 'h800, 0, 'h0, 1, 'h840);
    chk("t5_pending", redirect_valid, 1);
    #1 rst = 1;
    #1;
    chk("t5_upd_valid", upd_valid, 0);
    chk("t5_redirect", redirect_valid, 0);
    chk("t5_ex_ready", ex_ready, 1);
    #1 rst = 0;
    tick();

    // 6: 10 branches, 3 mispredicts
    upd_ready = 1;
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 1) send(1, A'('h9000 + i * 4), 0, 'h0, 1, 'hA000);
      else            send(1, A'('h9000 + i * 4), 1, 'hB000, 1, 'hB000);
    end
    tick();
`ifdef BRU_PERF_CNT_EN
    chk("t6_br", perf_br_cnt, 10);
    chk("t6_mp", perf_mp_cnt, 3);
`else
    chk("t6_br", perf_br_cnt, 0);
    chk("t6_mp", perf_mp_cnt, 0);
`endif
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
